// File: rtl/divider_pkg.sv
// Shared definitions for the histogram/CDF divider path.
//
// Contents:
//   - 3-bit state encodings for the divider scratch-memory sequencer,
//     wrapped in an enum for readable FSM code
//   - default scratch base addresses shared with the divider and the
//     scratch memory
//   - clog2 helper used to size index and counter widths
package divider_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_WAIT_RD  = 3'd2;
  localparam logic [2:0] S_WAIT_DIV = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_READ     = S_READ,
    ST_WAIT_RD  = S_WAIT_RD,
    ST_WAIT_DIV = S_WAIT_DIV,
    ST_WRITE    = S_WRITE,
    ST_DONE     = S_DONE
  } state_e;

  localparam int DEF_RD1_BASE = 0;
  localparam int DEF_RD2_BASE = 256;
  localparam int DEF_WT_BASE  = 512;

  // Ceiling log2, never smaller than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/divider_addr_gen.sv
// Index and address generator for the divider scratch-memory sequencer.
//
// Holds the entry index and the run configuration latched at start, and
// keeps the three scratch addresses registered so they stay stable between
// updates.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin a run: index=0, latch mode and length
//   advance           move to the next entry (issued at the end of WRITE)
//   wt_load           capture the write address for the current entry
//   mode              0: fixed denominator address, 1: indexed
//   cfg_len           requested entry count (0 or too large -> N_ENTRIES)
//   rd_addr1          numerator read address
//   rd_addr2          denominator read address
//   wt_addr           result write address
//   last              current index is the final entry of the run
module divider_addr_gen
  import divider_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int N_ENTRIES = 256,
  parameter int CNT_W     = clog2(N_ENTRIES + 1),
  parameter int RD1_BASE  = DEF_RD1_BASE,
  parameter int RD2_BASE  = DEF_RD2_BASE,
  parameter int WT_BASE   = DEF_WT_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic              wt_load,
  input  logic              mode,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              last
);

  localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(N_ENTRIES);
  localparam logic [ADDR_W-1:0] RD1_A   = ADDR_W'(RD1_BASE);
  localparam logic [ADDR_W-1:0] RD2_A   = ADDR_W'(RD2_BASE);
  localparam logic [ADDR_W-1:0] WT_A    = ADDR_W'(WT_BASE);

  logic [CNT_W-1:0]  idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;

  // Addresses are computed from the index the next READ will use, so they
  // are already valid during the READ cycle; base+i wraps modulo 2^ADDR_W.
  always_comb begin
    idx_d      = idx_q;
    len_d      = len_q;
    mode_d     = mode_q;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;
    wt_addr_d  = wt_addr_q;
    idx_inc    = idx_q + CNT_W'(1);

    if (start) begin
      idx_d      = '0;
      mode_d     = mode;
      len_d      = (cfg_len == '0 || cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
      rd_addr1_d = RD1_A;
      rd_addr2_d = RD2_A;
    end else if (advance) begin
      idx_d      = idx_inc;
      rd_addr1_d = RD1_A + ADDR_W'(idx_inc);
      rd_addr2_d = mode_q ? (RD2_A + ADDR_W'(idx_inc)) : RD2_A;
    end

    if (wt_load) begin
      wt_addr_d = WT_A + ADDR_W'(idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      wt_addr_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      wt_addr_q  <= wt_addr_d;
    end
  end

  assign rd_addr1 = rd_addr1_q;
  assign rd_addr2 = rd_addr2_q;
  assign wt_addr  = wt_addr_q;
  assign last     = (idx_q == (len_q - CNT_W'(1)));

endmodule

// File: rtl/divider_mem_seq.sv
// Divider scratch-memory sequencer.
//
// Walks up to N_ENTRIES CDF entries. For each entry it issues the numerator
// and denominator reads, waits RD_LAT cycles for the data, pulses
// sc_mem_rd_data_rdy to hand it to the divider, waits for div_done and then
// issues one scratch write of the result.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enable                start request (only honoured in IDLE)
//   mode                  denominator addressing mode, latched at start
//   cfg_len               entry count, latched at start
//   div_done              divider result valid (only honoured in WAIT_DIV)
//   sc_mem_rd_addr1/2     numerator / denominator read addresses
//   sc_mem_wt_addr        result write address
//   sc_mem_rd_data_rdy    one-cycle read-data-valid pulse
//   sc_mem_wt_en          one-cycle write strobe
//   sc_mem_rd_done        sticky: final read delivered
//   sc_mem_wt_done        sticky: final write issued
//   busy                  sequencer is not idle
module divider_mem_seq
  import divider_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int N_ENTRIES = 256,
  parameter int CNT_W     = clog2(N_ENTRIES + 1),
  parameter int RD_LAT    = 1,
  parameter int RD1_BASE  = DEF_RD1_BASE,
  parameter int RD2_BASE  = DEF_RD2_BASE,
  parameter int WT_BASE   = DEF_WT_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              div_done,
  output logic [ADDR_W-1:0] sc_mem_rd_addr1,
  output logic [ADDR_W-1:0] sc_mem_rd_addr2,
  output logic [ADDR_W-1:0] sc_mem_wt_addr,
  output logic              sc_mem_rd_data_rdy,
  output logic              sc_mem_wt_en,
  output logic              sc_mem_rd_done,
  output logic              sc_mem_wt_done,
  output logic              busy
);

  localparam int              LAT_W   = clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             rdy_q, rdy_d;
  logic             wt_en_q, wt_en_d;
  logic             rd_done_q, rd_done_d;
  logic             wt_done_q, wt_done_d;
  logic             busy_q, busy_d;
  logic             start, advance, wt_load, last;

  divider_addr_gen #(
    .ADDR_W    (ADDR_W),
    .N_ENTRIES (N_ENTRIES),
    .CNT_W     (CNT_W),
    .RD1_BASE  (RD1_BASE),
    .RD2_BASE  (RD2_BASE),
    .WT_BASE   (WT_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .advance  (advance),
    .wt_load  (wt_load),
    .mode     (mode),
    .cfg_len  (cfg_len),
    .rd_addr1 (sc_mem_rd_addr1),
    .rd_addr2 (sc_mem_rd_addr2),
    .wt_addr  (sc_mem_wt_addr),
    .last     (last)
  );

  // All status outputs are registered from the next state, so they line up
  // with the state they describe. WAIT_RD lasts RD_LAT cycles and the ready
  // pulse lands on its final cycle, RD_LAT cycles after READ.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    start   = 1'b0;
    advance = 1'b0;
    wt_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          start   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        lat_d   = '0;
        state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (lat_q == LAT_END) state_d = ST_WAIT_DIV;
        else                  lat_d   = lat_q + LAT_W'(1);
      end
      ST_WAIT_DIV: begin
        if (div_done) begin
          wt_load = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last) begin
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rdy_d     = (state_d == ST_WAIT_RD) && (lat_d == LAT_END);
    wt_en_d   = (state_d == ST_WRITE);
    busy_d    = (state_d != ST_IDLE);
    rd_done_d = start ? 1'b0 : (rd_done_q | (rdy_d & last));
    wt_done_d = start ? 1'b0 : (wt_done_q | (state_d == ST_DONE));
  end

  // Reset aborts a run on the spot; the write strobe is never raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      rdy_q     <= 1'b0;
      wt_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wt_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      rdy_q     <= rdy_d;
      wt_en_q   <= wt_en_d;
      rd_done_q <= rd_done_d;
      wt_done_q <= wt_done_d;
      busy_q    <= busy_d;
    end
  end

  assign sc_mem_rd_data_rdy = rdy_q;
  assign sc_mem_wt_en       = wt_en_q;
  assign sc_mem_rd_done     = rd_done_q;
  assign sc_mem_wt_done     = wt_done_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_divider_mem_seq.sv
// Directed testbench for divider_mem_seq with RD_LAT=2 and bases 0/16/32.
// A second instance with WT_BASE=16'hFFFE shares all inputs and is used to
// observe write-address wrap-around.
module tb_divider_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [8:0]  cfg_len;
  logic        div_done;

  logic [15:0] rd_addr1, rd_addr2, wt_addr;
  logic        rdy, wt_en, rd_done, wt_done, busy;

  logic [15:0] w_rd_addr1, w_rd_addr2, w_wt_addr;
  logic        w_rdy, w_wt_en, w_rd_done, w_wt_done, w_busy;

  int total_checks = 0;
  int bad_checks   = 0;
  int wr_count     = 0;
  logic [15:0] last_wt = '0;

  always #5 clk = ~clk;

  divider_mem_seq #(
    .ADDR_W(16), .N_ENTRIES(256), .CNT_W(9), .RD_LAT(2),
    .RD1_BASE(0), .RD2_BASE(16), .WT_BASE(32)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .cfg_len(cfg_len), .div_done(div_done),
    .sc_mem_rd_addr1(rd_addr1), .sc_mem_rd_addr2(rd_addr2),
    .sc_mem_wt_addr(wt_addr), .sc_mem_rd_data_rdy(rdy),
    .sc_mem_wt_en(wt_en), .sc_mem_rd_done(rd_done),
    .sc_mem_wt_done(wt_done), .busy(busy)
  );

  divider_mem_seq #(
    .ADDR_W(16), .N_ENTRIES(256), .CNT_W(9), .RD_LAT(2),
    .RD1_BASE(0), .RD2_BASE(16), .WT_BASE(32'hFFFE)
  ) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .cfg_len(cfg_len), .div_done(div_done),
    .sc_mem_rd_addr1(w_rd_addr1), .sc_mem_rd_addr2(w_rd_addr2),
    .sc_mem_wt_addr(w_wt_addr), .sc_mem_rd_data_rdy(w_rdy),
    .sc_mem_wt_en(w_wt_en), .sc_mem_rd_done(w_rd_done),
    .sc_mem_wt_done(w_wt_done), .busy(w_busy)
  );

  // Counts write strobes of the main instance and remembers the last address.
  always @(posedge clk) begin
    if (wt_en) begin
      wr_count = wr_count + 1;
      last_wt  = wt_addr;
    end
  end

  // Guards against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    assert (observed === expected) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic md, input logic [8:0] len);
    enable  = en;
    mode    = md;
    cfg_len = len;
  endtask

  // Walks one entry starting in its READ cycle; div_done is raised in the
  // third WAIT_DIV cycle. Returns in the following READ or DONE cycle.
  task automatic runEntry(input logic [15:0] a1, input logic [15:0] a2,
                          input logic [15:0] wa, input logic [15:0] wa2,
                          input logic is_last);
    checkOutput("read_addr1", rd_addr1, a1);
    checkOutput("read_addr2", rd_addr2, a2);
    checkOutput("read_wrap_addr1", w_rd_addr1, a1);
    checkOutput("read_busy", busy, 1);
    checkOutput("read_rdy", rdy, 0);
    tick;
    checkOutput("wait_rd_rdy_lo", rdy, 0);
    tick;
    checkOutput("wait_rd_rdy_hi", rdy, 1);
    tick;
    checkOutput("wait_div_rdy_lo", rdy, 0);
    checkOutput("wait_div_rd_done", rd_done, is_last);
    tick;
    tick;
    div_done = 1'b1;
    tick;
    div_done = 1'b0;
    checkOutput("write_en", wt_en, 1);
    checkOutput("write_addr", wt_addr, wa);
    checkOutput("write_wrap_addr", w_wt_addr, wa2);
    checkOutput("write_addr1_hold", rd_addr1, a1);
    tick;
    checkOutput("post_write_en", wt_en, 0);
    checkOutput("post_write_wt_done", wt_done, is_last);
  endtask

  initial begin
    logic [15:0] wrap_tbl [4];
    int          base_count;
    bit          seen_idle;
    logic        en_tog;

    wrap_tbl[0] = 16'hFFFE;
    wrap_tbl[1] = 16'hFFFF;
    wrap_tbl[2] = 16'h0000;
    wrap_tbl[3] = 16'h0001;

    reset    = 1'b1;
    div_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'd0);

    // Scenario 1: reset then 20 idle cycles with everything low.
    tick;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checkOutput("idle_outputs",
                  {rd_addr1, rd_addr2, wt_addr, rdy, wt_en, rd_done, wt_done, busy}, 64'd0);
      checkOutput("idle_wrap_outputs",
                  {w_rd_addr1, w_rd_addr2, w_wt_addr, w_rdy, w_wt_en, w_rd_done,
                   w_wt_done, w_busy}, 64'd0);
      tick;
    end

    // Scenarios 2 and 6: four entries, fixed denominator, wrapped write base.
    applyStimulus(1'b1, 1'b0, 9'd4);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd4);
    for (int i = 0; i < 4; i++)
      runEntry(16'(i), 16'd16, 16'(32 + i), wrap_tbl[i], i == 3);
    checkOutput("done_busy", busy, 1);
    tick;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rd_done", rd_done, 1);
    checkOutput("idle_wt_done", wt_done, 1);
    checkOutput("run4_writes", wr_count, 4);

    // Scenario 3a: indexed denominator, three entries.
    base_count = wr_count;
    applyStimulus(1'b1, 1'b1, 9'd3);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd0);
    checkOutput("restart_rd_done_clr", rd_done, 0);
    checkOutput("restart_wt_done_clr", wt_done, 0);
    for (int i = 0; i < 3; i++)
      runEntry(16'(i), 16'(16 + i), 16'(32 + i), 16'(16'hFFFE + i), i == 2);
    tick;
    checkOutput("run3_writes", wr_count - base_count, 3);

    // Scenario 3b: cfg_len=0 selects the full 256 entries.
    base_count = wr_count;
    applyStimulus(1'b1, 1'b0, 9'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 256; i++)
      runEntry(16'(i), 16'd16, 16'(32 + i), 16'(16'hFFFE + i), i == 255);
    tick;
    checkOutput("run256_writes", wr_count - base_count, 256);
    checkOutput("run256_last_addr", last_wt, 16'd287);

    // Scenario 4: div_done toggling every cycle and enable pulses mid-run.
    base_count = wr_count;
    applyStimulus(1'b1, 1'b0, 9'd5);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd5);
    seen_idle = 1'b0;
    en_tog    = 1'b0;
    for (int c = 0; c < 300 && !seen_idle; c++) begin
      div_done = ~div_done;
      en_tog   = ~en_tog;
      enable   = busy ? en_tog : 1'b0;
      tick;
      if (!busy) seen_idle = 1'b1;
    end
    enable   = 1'b0;
    div_done = 1'b0;
    checkOutput("toggle_run_ends", seen_idle, 1);
    checkOutput("toggle_writes", wr_count - base_count, 5);
    checkOutput("toggle_last_addr", last_wt, 16'd36);
    checkOutput("toggle_wt_done", wt_done, 1);
    tick;
    tick;
    checkOutput("toggle_no_restart", busy, 0);

    // Scenario 5: reset in WAIT_DIV of entry 2, then a fresh run.
    applyStimulus(1'b1, 1'b0, 9'd4);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd4);
    runEntry(16'd0, 16'd16, 16'd32, 16'hFFFE, 1'b0);
    runEntry(16'd1, 16'd16, 16'd33, 16'hFFFF, 1'b0);
    checkOutput("abort_entry2_addr1", rd_addr1, 16'd2);
    base_count = wr_count;
    tick;
    tick;
    tick;
    tick;
    reset    = 1'b1;
    div_done = 1'b1;
    tick;
    reset    = 1'b0;
    div_done = 1'b0;
    checkOutput("abort_outputs",
                {rd_addr1, rd_addr2, wt_addr, rdy, wt_en, rd_done, wt_done, busy}, 64'd0);
    tick;
    tick;
    checkOutput("abort_no_write", wr_count - base_count, 0);
    checkOutput("abort_idle", busy, 0);
    applyStimulus(1'b1, 1'b0, 9'd2);
    tick;
    applyStimulus(1'b0, 1'b0, 9'd2);
    runEntry(16'd0, 16'd16, 16'd32, 16'hFFFE, 1'b0);
    runEntry(16'd1, 16'd16, 16'd33, 16'hFFFF, 1'b1);
    tick;
    checkOutput("fresh_run_writes", wr_count - base_count, 2);
    checkOutput("fresh_run_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
